// File: rtl/controle_sessao_perfil.sv
// Session controller: latches a profile on login, grants/denies operations against its mask,
// and ends the session on logout or after TIMEOUT idle cycles. All outputs registered.
module controle_sessao_perfil #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] perfil_in,
    input  logic       login,
    input  logic       logout,
    input  logic       op_req,
    input  logic [1:0] op_sel,
    output logic       sessao_ativa,
    output logic [1:0] perfil_ativo,
    output logic [3:0] permissoes,
    output logic       op_ok,
    output logic       op_neg,
    output logic       expirou
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ATIVO    = 2'd1;
    localparam logic [1:0] ST_EXPIRADO = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sessao_q, sessao_d;
    logic [1:0]       perfil_q, perfil_d;
    logic [3:0]       perm_q, perm_d;
    logic             op_ok_q, op_ok_d;
    logic             op_neg_q, op_neg_d;
    logic             exp_q, exp_d;

    function automatic logic [3:0] decode_perfil(input logic [1:0] p);
        logic [3:0] m;
        case (p)
            2'b11:   m = 4'b1111;
            2'b10:   m = 4'b0111;
            2'b01:   m = 4'b0011;
            default: m = 4'b0001;
        endcase
        return m;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sessao_d = sessao_q;
        perfil_d = perfil_q;
        perm_d   = perm_q;
        op_ok_d  = 1'b0;
        op_neg_d = 1'b0;
        exp_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The mask is still empty here, so any request is refused.
                op_neg_d = op_req;
                if (login) begin
                    state_d  = ST_ATIVO;
                    perfil_d = perfil_in;
                    perm_d   = decode_perfil(perfil_in);
                    cnt_d    = '0;
                    sessao_d = 1'b1;
                end
            end
            ST_ATIVO: begin
                if (logout) begin
                    state_d  = ST_IDLE;
                    perfil_d = 2'b00;
                    perm_d   = 4'b0000;
                    sessao_d = 1'b0;
                    cnt_d    = '0;
                    op_neg_d = op_req;
                end else if (op_req) begin
                    cnt_d    = '0;
                    op_ok_d  = perm_q[op_sel];
                    op_neg_d = ~perm_q[op_sel];
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = ST_EXPIRADO;
                    perfil_d = 2'b00;
                    perm_d   = 4'b0000;
                    sessao_d = 1'b0;
                    cnt_d    = '0;
                    exp_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_EXPIRADO: begin
                state_d  = ST_IDLE;
                op_neg_d = op_req;
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                sessao_d = 1'b0;
                perfil_d = 2'b00;
                perm_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sessao_q <= 1'b0;
            perfil_q <= 2'b00;
            perm_q   <= 4'b0000;
            op_ok_q  <= 1'b0;
            op_neg_q <= 1'b0;
            exp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sessao_q <= sessao_d;
            perfil_q <= perfil_d;
            perm_q   <= perm_d;
            op_ok_q  <= op_ok_d;
            op_neg_q <= op_neg_d;
            exp_q    <= exp_d;
        end
    end

    assign sessao_ativa = sessao_q;
    assign perfil_ativo = perfil_q;
    assign permissoes   = perm_q;
    assign op_ok        = op_ok_q;
    assign op_neg       = op_neg_q;
    assign expirou      = exp_q;

endmodule

// File: tb/tb_controle_sessao_perfil.sv
// Bench for controle_sessao_perfil: directed scenarios plus random traffic against a
// cycle-level session model.
module tb_controle_sessao_perfil;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] perfil_in = 2'b00;
    logic       login = 1'b0;
    logic       logout = 1'b0;
    logic       op_req = 1'b0;
    logic [1:0] op_sel = 2'b00;
    logic       sessao_ativa;
    logic [1:0] perfil_ativo;
    logic [3:0] permissoes;
    logic       op_ok;
    logic       op_neg;
    logic       expirou;

    int total = 0;
    int bad   = 0;

    // Model: a live session with its profile and idle age, plus a pending-expiry cycle.
    bit       m_live;
    bit [1:0] m_prof;
    int       m_age;
    bit       m_expiring;
    bit       m_ok, m_neg, m_exp;

    controle_sessao_perfil #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .perfil_in(perfil_in), .login(login), .logout(logout),
        .op_req(op_req), .op_sel(op_sel), .sessao_ativa(sessao_ativa),
        .perfil_ativo(perfil_ativo), .permissoes(permissoes), .op_ok(op_ok),
        .op_neg(op_neg), .expirou(expirou)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] mdl_mask(input bit [1:0] p);
        int v;
        v = (1 << (int'(p) + 1)) - 1;
        return v[3:0];
    endfunction

    task automatic mdl_reset();
        m_live = 0; m_prof = 0; m_age = 0; m_expiring = 0;
        m_ok = 0; m_neg = 0; m_exp = 0;
    endtask

    task automatic mdl_edge();
        m_ok = 0; m_neg = 0; m_exp = 0;
        if (m_expiring) begin
            m_expiring = 0;
            m_neg = op_req;
        end else if (m_live) begin
            if (logout) begin
                m_live = 0;
                m_neg = op_req;
            end else if (op_req) begin
                m_age = 0;
                m_ok  = mdl_mask(m_prof)[op_sel];
                m_neg = !m_ok;
            end else if (m_age + 1 >= TIMEOUT) begin
                m_live = 0;
                m_expiring = 1;
                m_exp = 1;
            end else begin
                m_age++;
            end
        end else begin
            m_neg = op_req;
            if (login) begin
                m_live = 1;
                m_prof = perfil_in;
                m_age  = 0;
            end
        end
    endtask

    task automatic check_all();
        check_eq("sessao_ativa", sessao_ativa, m_live);
        check_eq("perfil_ativo", perfil_ativo, m_live ? m_prof : 2'b00);
        check_eq("permissoes", permissoes, m_live ? mdl_mask(m_prof) : 4'b0000);
        check_eq("op_ok", op_ok, m_ok);
        check_eq("op_neg", op_neg, m_neg);
        check_eq("expirou", expirou, m_exp);
        check_eq("ok_neg_exclusive", op_ok & op_neg, 1'b0);
    endtask

    task automatic step(input bit li, input bit lo, input bit rq, input bit [1:0] sel,
                        input bit [1:0] pf);
        login = li; logout = lo; op_req = rq; op_sel = sel; perfil_in = pf;
        @(posedge clk);
        mdl_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 2'd0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        mdl_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        reset = 1'b0;
    endtask

    initial begin : main
        int hi;
        mdl_reset();
        #2;
        check_all();
        @(posedge clk);
        #1 reset = 1'b0;

        // Reset in the middle of an ADM session with the idle count at 7.
        step(1, 0, 0, 2'd0, 2'b11);
        idle(7);
        check_eq("adm_live_before_reset", sessao_ativa, 1'b1);
        pulse_reset();
        idle(TIMEOUT + 3);
        check_eq("no_session_after_reset", sessao_ativa, 1'b0);

        // TESTER session: op class 3 refused, class 2 granted.
        step(1, 0, 0, 2'd0, 2'b10);
        check_eq("tester_perm", permissoes, 4'b0111);
        check_eq("tester_prof", perfil_ativo, 2'b10);
        step(0, 0, 1, 2'd3, 2'd0);
        check_eq("tester_op3_neg", op_neg, 1'b1);
        step(0, 0, 1, 2'd2, 2'd0);
        check_eq("tester_op2_ok", op_ok, 1'b1);
        step(0, 1, 0, 2'd0, 2'd0);

        // USER timeout, then an op_req at idle cycle 15 restarting the window.
        step(1, 0, 0, 2'd0, 2'b01);
        idle(14);
        step(0, 0, 1, 2'd1, 2'd0);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (sessao_ativa) hi++;
            if (expirou) break;
            step(0, 0, 0, 2'd0, 2'd0);
        end
        check_eq("timeout_high_cycles", hi, TIMEOUT);
        check_eq("timeout_expirou", expirou, 1'b1);
        // Login during the expiry cycle is ignored; the next one is accepted.
        step(1, 0, 0, 2'd0, 2'b11);
        check_eq("login_in_expiry_ignored", sessao_ativa, 1'b0);
        step(1, 0, 0, 2'd0, 2'b11);
        check_eq("login_after_expiry", sessao_ativa, 1'b1);

        // ADM: logout together with op_req on class 0 is refused.
        step(0, 1, 1, 2'd0, 2'd0);
        check_eq("logout_op_neg", op_neg, 1'b1);
        check_eq("logout_perm", permissoes, 4'b0000);
        check_eq("logout_no_exp", expirou, 1'b0);

        // GUEST session is not re-latched by a second login.
        step(1, 0, 0, 2'd0, 2'b00);
        step(1, 0, 0, 2'd0, 2'b11);
        check_eq("guest_prof_kept", perfil_ativo, 2'b00);
        check_eq("guest_perm_kept", permissoes, 4'b0001);
        step(0, 1, 0, 2'd0, 2'd0);
        step(0, 0, 1, 2'd0, 2'd0);
        check_eq("idle_op_neg", op_neg, 1'b1);

        // Random traffic: busy phase, then a sparse phase that reaches timeouts.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 35, 2'($urandom), 2'($urandom));
        pulse_reset();
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < 4, 2'($urandom), 2'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
